// File: rtl/noc_vc_port_buffer.sv
// Router input-port buffer: per-VC flit FIFOs, round-robin VC arbitration onto one registered output.
// Optional wormhole packet locking when NOC_VC_PORT_BUFFER_PKT_LOCK_EN is defined.
module noc_vc_port_buffer #(
    parameter int unsigned DATA_W = 35,
    parameter int unsigned NUM_VC = 2,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned VCW   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              RST_,
    input  logic [DATA_W-1:0] IDATA,
    input  logic              IVALID,
    input  logic [VCW-1:0]    IVCH,
    output logic [NUM_VC-1:0] ORDY,
    output logic [NUM_VC-1:0] OACK,
    output logic [DATA_W-1:0] ODATA,
    output logic              OVALID,
    output logic [VCW-1:0]    OVCH,
    input  logic [NUM_VC-1:0] IRDY,
    output logic [NUM_VC-1:0] OLCK,
    output logic              ERR
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
    logic [PW-1:0]     wptr [NUM_VC];
    logic [PW-1:0]     rptr [NUM_VC];
    logic [CW-1:0]     cnt  [NUM_VC];
    logic [CW-1:0]     cnt_nxt_c [NUM_VC];
    logic [VCW-1:0]    rr_ptr;

    logic [NUM_VC-1:0] push_vec_c;
    logic              push_err_c;
    logic [NUM_VC-1:0] elig_c;
    logic [NUM_VC-1:0] pop_vec_c;
    logic              grant_c;
    logic [VCW-1:0]    gnt_vc_c;
    logic [VCW-1:0]    cand_c;
    logic [DATA_W-1:0] head_flit_c;

`ifdef NOC_VC_PORT_BUFFER_PKT_LOCK_EN
    logic              locked;
    logic [VCW-1:0]    lock_vc;
`endif

    // Push decode: out-of-range VC or a VC not signalling ready drops the flit.
    always_comb begin
        push_vec_c = '0;
        push_err_c = 1'b0;
        if (IVALID) begin
            if ((32'(IVCH) < NUM_VC) && ORDY[IVCH]) begin
                push_vec_c[IVCH] = 1'b1;
            end else begin
                push_err_c = 1'b1;
            end
        end
    end

    // Round-robin search starting one past the last granted VC.
    always_comb begin
        elig_c   = '0;
        grant_c  = 1'b0;
        gnt_vc_c = rr_ptr;
        cand_c   = rr_ptr;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            elig_c[v] = (cnt[v] != '0) && IRDY[v];
        end
`ifdef NOC_VC_PORT_BUFFER_PKT_LOCK_EN
        if (locked) begin
            elig_c = elig_c & (NUM_VC'(1) << lock_vc);
        end
`endif
        for (int unsigned i = 1; i <= NUM_VC; i++) begin
            cand_c = VCW'((32'(rr_ptr) + i) % NUM_VC);
            if (!grant_c && elig_c[cand_c]) begin
                grant_c  = 1'b1;
                gnt_vc_c = cand_c;
            end
        end
        pop_vec_c   = grant_c ? (NUM_VC'(1) << gnt_vc_c) : '0;
        head_flit_c = mem[gnt_vc_c][rptr[gnt_vc_c]];
    end

    always_comb begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            cnt_nxt_c[v] = cnt[v] + CW'(push_vec_c[v]) - CW'(pop_vec_c[v]);
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (push_vec_c[v]) begin
                mem[v][wptr[v]] <= IDATA;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                wptr[v] <= '0;
                rptr[v] <= '0;
                cnt[v]  <= '0;
            end
            rr_ptr <= VCW'(NUM_VC - 1);
            ORDY   <= '0;
            OACK   <= '0;
            ODATA  <= '0;
            OVALID <= 1'b0;
            OVCH   <= '0;
            ERR    <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (push_vec_c[v]) begin
                    wptr[v] <= wptr[v] + PW'(1);
                end
                if (pop_vec_c[v]) begin
                    rptr[v] <= rptr[v] + PW'(1);
                end
                cnt[v]  <= cnt_nxt_c[v];
                ORDY[v] <= (cnt_nxt_c[v] < CW'(DEPTH));
            end
            OACK   <= pop_vec_c;
            OVALID <= grant_c;
            if (grant_c) begin
                ODATA  <= head_flit_c;
                OVCH   <= gnt_vc_c;
                rr_ptr <= gnt_vc_c;
            end
            if (push_err_c) begin
                ERR <= 1'b1;
            end
        end
    end

`ifdef NOC_VC_PORT_BUFFER_PKT_LOCK_EN
    // A HEAD-without-TAIL grant pins the arbiter until that VC's TAIL leaves.
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            locked  <= 1'b0;
            lock_vc <= '0;
            OLCK    <= '0;
        end else if (grant_c) begin
            if (head_flit_c[DATA_W-2]) begin
                locked <= 1'b0;
                OLCK   <= '0;
            end else if (head_flit_c[DATA_W-1]) begin
                locked  <= 1'b1;
                lock_vc <= gnt_vc_c;
                OLCK    <= NUM_VC'(1) << gnt_vc_c;
            end
        end
    end
`else
    assign OLCK = '0;
`endif

endmodule

// File: tb/tb_noc_vc_port_buffer.sv
// Directed self-checking bench for noc_vc_port_buffer (default 35-bit, 2 VC, depth 4).
module tb_noc_vc_port_buffer;

    localparam int unsigned DATA_W = 35;
    localparam int unsigned NUM_VC = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned VCW    = 1;

    logic              clk;
    logic              RST_;
    logic [DATA_W-1:0] IDATA;
    logic              IVALID;
    logic [VCW-1:0]    IVCH;
    logic [NUM_VC-1:0] ORDY;
    logic [NUM_VC-1:0] OACK;
    logic [DATA_W-1:0] ODATA;
    logic              OVALID;
    logic [VCW-1:0]    OVCH;
    logic [NUM_VC-1:0] IRDY;
    logic [NUM_VC-1:0] OLCK;
    logic              ERR;

    int errors = 0;
    int checks = 0;

    noc_vc_port_buffer #(
        .DATA_W(DATA_W),
        .NUM_VC(NUM_VC),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .RST_  (RST_),
        .IDATA (IDATA),
        .IVALID(IVALID),
        .IVCH  (IVCH),
        .ORDY  (ORDY),
        .OACK  (OACK),
        .ODATA (ODATA),
        .OVALID(OVALID),
        .OVCH  (OVCH),
        .IRDY  (IRDY),
        .OLCK  (OLCK),
        .ERR   (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [VCW-1:0] vc, input logic [DATA_W-1:0] d);
        IVALID = 1'b1;
        IVCH   = vc;
        IDATA  = d;
        step();
        IVALID = 1'b0;
    endtask

    task automatic do_reset();
        RST_ = 1'b0;
        IRDY = '0;
        step();
        step();
        RST_ = 1'b1;
        step();
    endtask

    logic [DATA_W-1:0] lk_d  [4];
    logic [VCW-1:0]    lk_vc [4];
    logic [NUM_VC-1:0] lk_lck[4];
    logic [DATA_W-1:0] rr_d  [6];

    initial begin
        RST_   = 1'b0;
        IDATA  = '0;
        IVALID = 1'b0;
        IVCH   = '0;
        IRDY   = '0;

        // Reset then idle
        repeat (3) step();
        check("rst_ordy",   64'(ORDY),   64'h0);
        check("rst_oack",   64'(OACK),   64'h0);
        check("rst_ovalid", 64'(OVALID), 64'h0);
        check("rst_odata",  64'(ODATA),  64'h0);
        check("rst_ovch",   64'(OVCH),   64'h0);
        check("rst_olck",   64'(OLCK),   64'h0);
        check("rst_err",    64'(ERR),    64'h0);
        RST_ = 1'b1;
        step();
        check("rel_ordy",   64'(ORDY),   64'h3);
        check("rel_ovalid", 64'(OVALID), 64'h0);

        // Single flit, one-cycle latency
        IRDY = 2'b11;
        push(1'b1, 35'h1_2345_6789);
        check("sf_idle",   64'(OVALID), 64'h0);
        step();
        check("sf_ovalid", 64'(OVALID), 64'h1);
        check("sf_ovch",   64'(OVCH),   64'h1);
        check("sf_odata",  64'(ODATA),  64'h1_2345_6789);
        check("sf_oack",   64'(OACK),   64'h2);
        step();
        check("sf_ovalid_off", 64'(OVALID), 64'h0);
        check("sf_oack_off",   64'(OACK),   64'h0);
        check("sf_odata_hold", 64'(ODATA),  64'h1_2345_6789);

        // Fill and overflow VC0
        IRDY = 2'b00;
        for (int i = 0; i < 3; i++) push(1'b0, DATA_W'(32'hA0 + i));
        check("fill3_ordy", 64'(ORDY), 64'h3);
        push(1'b0, DATA_W'(32'hA3));
        check("fill4_ordy", 64'(ORDY), 64'h2);
        check("fill4_err",  64'(ERR),  64'h0);
        push(1'b0, DATA_W'(32'hA4));
        check("ovf_err",    64'(ERR),  64'h1);
        IRDY = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_ovalid", 64'(OVALID), 64'h1);
            check("drain_odata",  64'(ODATA),  64'hA0 + 64'(i));
            check("drain_oack",   64'(OACK),   64'h1);
            if (i == 0) check("drain_ordy", 64'(ORDY), 64'h3);
        end
        step();
        check("drain_done", 64'(OVALID), 64'h0);
        check("err_sticky", 64'(ERR),    64'h1);

        // Round-robin alternation
        do_reset();
        check("rr_err_clr", 64'(ERR), 64'h0);
        for (int i = 0; i < 3; i++) begin
            push(1'b0, DATA_W'(32'hB0 + i));
            push(1'b1, DATA_W'(32'hC0 + i));
        end
        rr_d[0] = 35'hB0; rr_d[1] = 35'hC0; rr_d[2] = 35'hB1;
        rr_d[3] = 35'hC1; rr_d[4] = 35'hB2; rr_d[5] = 35'hC2;
        IRDY = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_ovalid", 64'(OVALID), 64'h1);
            check("rr_ovch",   64'(OVCH),   64'(i % 2));
            check("rr_odata",  64'(ODATA),  64'(rr_d[i]));
        end
        step();
        check("rr_done", 64'(OVALID), 64'h0);

        // Back-pressure on VC1
        IRDY = 2'b00;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, DATA_W'(32'hD0 + i));
            push(1'b1, DATA_W'(32'hE0 + i));
        end
        IRDY = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ovalid", 64'(OVALID), 64'h1);
            check("bp_ovch",   64'(OVCH),   64'h0);
            check("bp_odata",  64'(ODATA),  64'hD0 + 64'(i));
        end
        step();
        check("bp_hold", 64'(OVALID), 64'h0);
        IRDY = 2'b00;

        // Packet lock
        do_reset();
        push(1'b0, {2'b10, 33'h11});
        push(1'b0, {2'b00, 33'h12});
        push(1'b0, {2'b01, 33'h13});
        push(1'b1, {2'b11, 33'h21});
`ifdef NOC_VC_PORT_BUFFER_PKT_LOCK_EN
        lk_d[0] = {2'b10, 33'h11}; lk_vc[0] = 1'b0; lk_lck[0] = 2'b01;
        lk_d[1] = {2'b00, 33'h12}; lk_vc[1] = 1'b0; lk_lck[1] = 2'b01;
        lk_d[2] = {2'b01, 33'h13}; lk_vc[2] = 1'b0; lk_lck[2] = 2'b00;
        lk_d[3] = {2'b11, 33'h21}; lk_vc[3] = 1'b1; lk_lck[3] = 2'b00;
`else
        lk_d[0] = {2'b10, 33'h11}; lk_vc[0] = 1'b0; lk_lck[0] = 2'b00;
        lk_d[1] = {2'b11, 33'h21}; lk_vc[1] = 1'b1; lk_lck[1] = 2'b00;
        lk_d[2] = {2'b00, 33'h12}; lk_vc[2] = 1'b0; lk_lck[2] = 2'b00;
        lk_d[3] = {2'b01, 33'h13}; lk_vc[3] = 1'b0; lk_lck[3] = 2'b00;
`endif
        IRDY = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lk_ovalid", 64'(OVALID), 64'h1);
            check("lk_ovch",   64'(OVCH),   64'(lk_vc[i]));
            check("lk_odata",  64'(ODATA),  64'(lk_d[i]));
            check("lk_olck",   64'(OLCK),   64'(lk_lck[i]));
        end
        step();
        check("lk_done", 64'(OVALID), 64'h0);

        // Asynchronous reset mid-drain
        IRDY = 2'b00;
        for (int i = 0; i < 4; i++) push(1'b0, DATA_W'(32'hF0 + i));
        push(1'b0, DATA_W'(32'hF4));
        check("ar_err_pre", 64'(ERR), 64'h1);
        IRDY = 2'b01;
        step();
        check("ar_ovalid_pre", 64'(OVALID), 64'h1);
        #2;
        RST_ = 1'b0;
        #1;
        check("ar_ovalid", 64'(OVALID), 64'h0);
        check("ar_oack",   64'(OACK),   64'h0);
        check("ar_ordy",   64'(ORDY),   64'h0);
        check("ar_err",    64'(ERR),    64'h0);
        step();
        RST_ = 1'b1;
        IRDY = 2'b11;
        step();
        check("ar_ordy_rel", 64'(ORDY), 64'h3);
        for (int i = 0; i < 5; i++) begin
            check("ar_no_flit", 64'(OVALID), 64'h0);
            check("ar_no_ack",  64'(OACK),   64'h0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
